// File: rtl/tlb_fork_isr.sv
// Forks one translated DMA request into independently handshaked host and card legs,
// then retires requests in order as the selected done source(s) report completion.
module tlb_fork_isr #(
    parameter int PADDR_BITS = 64,
    parameter int LEN_BITS   = 28,
    parameter int CTL_BITS   = 8,
    parameter int DEST_BITS  = 4,
    parameter int N_OUT      = 8,
    parameter int DONE_MODE  = 0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    snk_valid,
    output logic                    snk_ready,
    input  logic [PADDR_BITS-1:0]   snk_paddr_host,
    input  logic [PADDR_BITS-1:0]   snk_paddr_card,
    input  logic [LEN_BITS-1:0]     snk_len,
    input  logic [CTL_BITS-1:0]     snk_ctl,
    input  logic [DEST_BITS-1:0]    snk_dest,
    input  logic                    snk_isr,
    output logic                    snk_done,
    output logic                    snk_isr_return,
    output logic                    host_valid,
    input  logic                    host_ready,
    output logic [PADDR_BITS-1:0]   host_paddr,
    output logic [LEN_BITS-1:0]     host_len,
    output logic [CTL_BITS-1:0]     host_ctl,
    output logic [DEST_BITS-1:0]    host_dest,
    input  logic                    host_done,
    output logic                    card_valid,
    input  logic                    card_ready,
    output logic [PADDR_BITS-1:0]   card_paddr,
    output logic [LEN_BITS-1:0]     card_len,
    output logic [CTL_BITS-1:0]     card_ctl,
    output logic [DEST_BITS-1:0]    card_dest,
    input  logic                    card_done,
    output logic [$clog2(N_OUT):0]  outstanding,
    output logic                    err_spurious
);

    localparam int PW = $clog2(N_OUT);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(N_OUT);
    localparam bit USE_HOST = (DONE_MODE != 0);
    localparam bit USE_CARD = (DONE_MODE != 1);

    typedef enum logic {IDLE, FORK} state_t;

    state_t          state, state_nxt;
    logic [N_OUT-1:0] tag_q;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt_host, cnt_card;
    logic [CW-1:0]   eff_host, eff_card;
    logic            accept, host_fire, card_fire, comp;
    logic            spur_host, spur_card, inc_host, inc_card;

    function automatic logic [CW-1:0] ext1(input logic b);
        return {{(CW-1){1'b0}}, b};
    endfunction

    // Ready depends on registered state only, never on either leg's ready.
    assign snk_ready = (state == IDLE) && (outstanding < FULL);
    assign accept    = snk_valid && snk_ready;
    assign host_fire = host_valid && host_ready;
    assign card_fire = card_valid && card_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = FORK;
            FORK: if ((!host_valid || host_ready) && (!card_valid || card_ready))
                      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A done that would push its counter past the outstanding count is dropped and flagged.
    assign spur_host = USE_HOST && host_done && (cnt_host == outstanding);
    assign spur_card = USE_CARD && card_done && (cnt_card == outstanding);
    assign inc_host  = USE_HOST && host_done && !spur_host;
    assign inc_card  = USE_CARD && card_done && !spur_card;
    assign eff_host  = cnt_host + ext1(inc_host);
    assign eff_card  = cnt_card + ext1(inc_card);

    // Incoming dones count toward this cycle's completion so snk_done lags by one cycle.
    assign comp = (outstanding != '0)
               && (!USE_HOST || (eff_host != '0))
               && (!USE_CARD || (eff_card != '0));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state          <= IDLE;
            host_valid     <= 1'b0;
            card_valid     <= 1'b0;
            host_paddr     <= '0;
            host_len       <= '0;
            host_ctl       <= '0;
            host_dest      <= '0;
            card_paddr     <= '0;
            card_len       <= '0;
            card_ctl       <= '0;
            card_dest      <= '0;
            tag_q          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            outstanding    <= '0;
            cnt_host       <= '0;
            cnt_card       <= '0;
            snk_done       <= 1'b0;
            snk_isr_return <= 1'b0;
            err_spurious   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                host_valid     <= 1'b1;
                card_valid     <= 1'b1;
                host_paddr     <= snk_paddr_host;
                card_paddr     <= snk_paddr_card;
                host_len       <= snk_len;
                card_len       <= snk_len;
                host_ctl       <= snk_ctl;
                card_ctl       <= snk_ctl;
                host_dest      <= snk_dest;
                card_dest      <= snk_dest;
                tag_q[wr_ptr]  <= snk_isr;
                wr_ptr         <= wr_ptr + PW'(1);
            end else begin
                if (host_fire) host_valid <= 1'b0;
                if (card_fire) card_valid <= 1'b0;
            end
            if (comp) rd_ptr <= rd_ptr + PW'(1);
            outstanding    <= outstanding + ext1(accept) - ext1(comp);
            cnt_host       <= eff_host - ext1(comp && USE_HOST);
            cnt_card       <= eff_card - ext1(comp && USE_CARD);
            snk_done       <= comp;
            snk_isr_return <= comp && tag_q[rd_ptr];
            if (spur_host || spur_card) err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tlb_fork_isr.sv
// Directed bench for tlb_fork_isr: a card-done instance (mode 0) and a both-done instance (mode 2).
module tb_tlb_fork_isr;

    logic        aclk = 1'b0;
    logic        areset;
    always #5 aclk = ~aclk;

    logic [63:0] snk_paddr_host, snk_paddr_card;
    logic [27:0] snk_len;
    logic [7:0]  snk_ctl;
    logic [3:0]  snk_dest;
    logic        snk_isr;

    logic        snk_valid, snk_ready, snk_done, snk_isr_return, err_spurious;
    logic        host_valid, host_ready, host_done, card_valid, card_ready, card_done;
    logic [63:0] host_paddr, card_paddr;
    logic [27:0] host_len, card_len;
    logic [7:0]  host_ctl, card_ctl;
    logic [3:0]  host_dest, card_dest;
    logic [3:0]  outstanding;

    logic        m2_snk_valid, m2_snk_ready, m2_snk_done, m2_snk_isr_return, m2_err_spurious;
    logic        m2_host_valid, m2_host_ready, m2_host_done, m2_card_valid, m2_card_ready, m2_card_done;
    logic [63:0] m2_host_paddr, m2_card_paddr;
    logic [27:0] m2_host_len, m2_card_len;
    logic [7:0]  m2_host_ctl, m2_card_ctl;
    logic [3:0]  m2_host_dest, m2_card_dest;
    logic [3:0]  m2_outstanding;

    tlb_fork_isr #(.DONE_MODE(0)) u0 (
        .aclk(aclk), .areset(areset),
        .snk_valid(snk_valid), .snk_ready(snk_ready),
        .snk_paddr_host(snk_paddr_host), .snk_paddr_card(snk_paddr_card),
        .snk_len(snk_len), .snk_ctl(snk_ctl), .snk_dest(snk_dest), .snk_isr(snk_isr),
        .snk_done(snk_done), .snk_isr_return(snk_isr_return),
        .host_valid(host_valid), .host_ready(host_ready), .host_paddr(host_paddr),
        .host_len(host_len), .host_ctl(host_ctl), .host_dest(host_dest), .host_done(host_done),
        .card_valid(card_valid), .card_ready(card_ready), .card_paddr(card_paddr),
        .card_len(card_len), .card_ctl(card_ctl), .card_dest(card_dest), .card_done(card_done),
        .outstanding(outstanding), .err_spurious(err_spurious)
    );

    tlb_fork_isr #(.DONE_MODE(2)) u2 (
        .aclk(aclk), .areset(areset),
        .snk_valid(m2_snk_valid), .snk_ready(m2_snk_ready),
        .snk_paddr_host(snk_paddr_host), .snk_paddr_card(snk_paddr_card),
        .snk_len(snk_len), .snk_ctl(snk_ctl), .snk_dest(snk_dest), .snk_isr(snk_isr),
        .snk_done(m2_snk_done), .snk_isr_return(m2_snk_isr_return),
        .host_valid(m2_host_valid), .host_ready(m2_host_ready), .host_paddr(m2_host_paddr),
        .host_len(m2_host_len), .host_ctl(m2_host_ctl), .host_dest(m2_host_dest),
        .host_done(m2_host_done),
        .card_valid(m2_card_valid), .card_ready(m2_card_ready), .card_paddr(m2_card_paddr),
        .card_len(m2_card_len), .card_ctl(m2_card_ctl), .card_dest(m2_card_dest),
        .card_done(m2_card_done),
        .outstanding(m2_outstanding), .err_spurious(m2_err_spurious)
    );

    typedef struct {
        logic [63:0] ph;
        logic [63:0] pc;
        logic [27:0] len;
        logic [7:0]  ctl;
        logic [3:0]  dest;
    } req_t;

    req_t hq[$];
    req_t cq[$];
    bit   tq0[$];
    bit   tq2[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Scoreboard monitors: leg payloads popped on each handshake, done tags popped on each snk_done.
    always @(negedge aclk) begin : mon
        req_t r;
        bit   e;
        if (!areset) begin
            if (host_valid && host_ready) begin
                if (hq.size() == 0) chk("host_unexpected", host_valid, 1'b0);
                else begin
                    r = hq.pop_front();
                    chk("host_paddr", host_paddr, r.ph);
                    chk("host_len", 64'(host_len), 64'(r.len));
                    chk("host_ctl", 64'(host_ctl), 64'(r.ctl));
                    chk("host_dest", 64'(host_dest), 64'(r.dest));
                end
            end
            if (card_valid && card_ready) begin
                if (cq.size() == 0) chk("card_unexpected", card_valid, 1'b0);
                else begin
                    r = cq.pop_front();
                    chk("card_paddr", card_paddr, r.pc);
                    chk("card_len", 64'(card_len), 64'(r.len));
                    chk("card_ctl", 64'(card_ctl), 64'(r.ctl));
                    chk("card_dest", 64'(card_dest), 64'(r.dest));
                end
            end
            if (snk_done) begin
                if (tq0.size() == 0) chk("done0_unexpected", snk_done, 1'b0);
                else begin
                    e = tq0.pop_front();
                    chk("isr_return0", snk_isr_return, e);
                end
            end else if (snk_isr_return) chk("isr_without_done0", snk_isr_return, 1'b0);
            if (m2_snk_done) begin
                if (tq2.size() == 0) chk("done2_unexpected", m2_snk_done, 1'b0);
                else begin
                    e = tq2.pop_front();
                    chk("isr_return2", m2_snk_isr_return, e);
                end
            end else if (m2_snk_isr_return) chk("isr_without_done2", m2_snk_isr_return, 1'b0);
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input int which, input logic [63:0] ph, input logic [63:0] pc,
                         input logic [27:0] len, input logic [7:0] ctl, input logic [3:0] dest,
                         input logic isr);
        req_t r;
        bit   ok = 1'b0;
        r = '{ph, pc, len, ctl, dest};
        snk_paddr_host = ph;
        snk_paddr_card = pc;
        snk_len  = len;
        snk_ctl  = ctl;
        snk_dest = dest;
        snk_isr  = isr;
        if (which == 0) snk_valid = 1'b1;
        else m2_snk_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if ((which == 0 && snk_ready) || (which != 0 && m2_snk_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("issue_accepted", ok, 1'b1);
        if (ok) begin
            if (which == 0) begin
                hq.push_back(r);
                cq.push_back(r);
                tq0.push_back(isr);
            end else tq2.push_back(isr);
        end
        step();
        snk_valid = 1'b0;
        m2_snk_valid = 1'b0;
    endtask

    task automatic single_req();
        issue(0, 64'h1000, 64'h2000, 28'd64, 8'h5a, 4'h3, 1'b0);
        @(negedge aclk);
        chk("s1_host_valid", host_valid, 1'b1);
        chk("s1_card_valid", card_valid, 1'b1);
        chk("s1_outstanding", outstanding, 4'd1);
        chk("s1_ready_fork", snk_ready, 1'b0);
        step();
        @(negedge aclk);
        chk("s1_host_cleared", host_valid, 1'b0);
        chk("s1_card_cleared", card_valid, 1'b0);
        chk("s1_ready_idle", snk_ready, 1'b1);
        step();
        card_done = 1'b1;
        step();
        card_done = 1'b0;
        @(negedge aclk);
        chk("s1_done", snk_done, 1'b1);
        chk("s1_isr_return", snk_isr_return, 1'b0);
        chk("s1_outstanding_0", outstanding, 4'd0);
        step();
        @(negedge aclk);
        chk("s1_done_one_cycle", snk_done, 1'b0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d errors of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        snk_valid = 1'b0; m2_snk_valid = 1'b0;
        snk_paddr_host = '0; snk_paddr_card = '0;
        snk_len = '0; snk_ctl = '0; snk_dest = '0; snk_isr = 1'b0;
        host_ready = 1'b1; card_ready = 1'b1; host_done = 1'b0; card_done = 1'b0;
        m2_host_ready = 1'b1; m2_card_ready = 1'b1; m2_host_done = 1'b0; m2_card_done = 1'b0;

        @(negedge aclk);
        chk("rst_host_valid", host_valid, 1'b0);
        chk("rst_card_valid", card_valid, 1'b0);
        chk("rst_outstanding", outstanding, 4'd0);
        chk("rst_done", snk_done, 1'b0);
        chk("rst_err", err_spurious, 1'b0);
        chk("rst_ready", snk_ready, 1'b1);
        step();
        areset = 1'b0;
        step();

        single_req();

        // Skewed legs: host held off for five cycles.
        host_ready = 1'b0;
        issue(0, 64'h3000, 64'h4000, 28'd128, 8'h11, 4'h1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("s2_host_held", host_valid, 1'b1);
            chk("s2_host_paddr_stable", host_paddr, 64'h3000);
            chk("s2_ready_low", snk_ready, 1'b0);
            chk("s2_card_valid", card_valid, (i == 0));
            step();
        end
        host_ready = 1'b1;
        @(negedge aclk);
        chk("s2_host_last", host_valid, 1'b1);
        step();
        @(negedge aclk);
        chk("s2_host_cleared", host_valid, 1'b0);
        chk("s2_ready_idle", snk_ready, 1'b1);
        step();
        host_done = 1'b1;
        step();
        host_done = 1'b0;
        @(negedge aclk);
        chk("s2_host_done_ignored", snk_done, 1'b0);
        chk("s2_outstanding_kept", outstanding, 4'd1);
        step();
        card_done = 1'b1;
        step();
        card_done = 1'b0;
        @(negedge aclk);
        chk("s2_done", snk_done, 1'b1);
        step();

        // Fill to eight outstanding, then complete one to admit a ninth.
        for (int k = 0; k < 8; k++)
            issue(0, 64'h10000 + 64'(k) * 64'h100, 64'h20000 + 64'(k) * 64'h100,
                  28'(32 + k), 8'(k), 4'(k), k[0]);
        step();
        @(negedge aclk);
        chk("s3_full_count", outstanding, 4'd8);
        chk("s3_full_ready", snk_ready, 1'b0);
        step();
        snk_paddr_host = 64'h9000; snk_paddr_card = 64'h9800;
        snk_len = 28'd99; snk_ctl = 8'hc3; snk_dest = 4'h9; snk_isr = 1'b1;
        snk_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("s3_blocked", snk_ready, 1'b0);
            step();
        end
        card_done = 1'b1;
        @(negedge aclk);
        chk("s3_ready_still_low", snk_ready, 1'b0);
        step();
        card_done = 1'b0;
        @(negedge aclk);
        chk("s3_done", snk_done, 1'b1);
        chk("s3_ready_reopen", snk_ready, 1'b1);
        chk("s3_count_7", outstanding, 4'd7);
        hq.push_back('{64'h9000, 64'h9800, 28'd99, 8'hc3, 4'h9});
        cq.push_back('{64'h9000, 64'h9800, 28'd99, 8'hc3, 4'h9});
        tq0.push_back(1'b1);
        step();
        snk_valid = 1'b0;
        @(negedge aclk);
        chk("s3_ninth_in", outstanding, 4'd8);
        for (int k = 0; k < 8; k++) begin
            step();
            card_done = 1'b1;
            step();
            card_done = 1'b0;
            @(negedge aclk);
            chk("s3_drain_done", snk_done, 1'b1);
        end
        step();
        @(negedge aclk);
        chk("s3_drained", outstanding, 4'd0);
        step();

        // Both-done mode: ISR request completes only once both sources have reported.
        issue(2, 64'ha000, 64'hb000, 28'd16, 8'h01, 4'h2, 1'b1);
        issue(2, 64'ha100, 64'hb100, 28'd8, 8'h02, 4'h4, 1'b0);
        step();
        m2_host_done = 1'b1;
        step();
        m2_host_done = 1'b0;
        @(negedge aclk);
        chk("s4_t1_no_done", m2_snk_done, 1'b0);
        step();
        @(negedge aclk);
        chk("s4_t2_no_done", m2_snk_done, 1'b0);
        chk("s4_outstanding_2", m2_outstanding, 4'd2);
        step();
        m2_card_done = 1'b1;
        @(negedge aclk);
        chk("s4_t3_no_done", m2_snk_done, 1'b0);
        step();
        m2_card_done = 1'b0;
        @(negedge aclk);
        chk("s4_t4_done", m2_snk_done, 1'b1);
        chk("s4_t4_isr_return", m2_snk_isr_return, 1'b1);
        step();
        @(negedge aclk);
        chk("s4_t5_no_done", m2_snk_done, 1'b0);
        chk("s4_outstanding_1", m2_outstanding, 4'd1);
        step();
        m2_host_done = 1'b1;
        m2_card_done = 1'b1;
        step();
        m2_host_done = 1'b0;
        m2_card_done = 1'b0;
        @(negedge aclk);
        chk("s4_second_done", m2_snk_done, 1'b1);
        chk("s4_second_no_isr", m2_snk_isr_return, 1'b0);
        chk("s4_outstanding_0", m2_outstanding, 4'd0);
        step();

        // Spurious done with nothing outstanding.
        card_done = 1'b1;
        step();
        card_done = 1'b0;
        @(negedge aclk);
        chk("s5_err_set", err_spurious, 1'b1);
        chk("s5_no_done", snk_done, 1'b0);
        step();
        @(negedge aclk);
        chk("s5_err_sticky", err_spurious, 1'b1);
        chk("s5_outstanding_0", outstanding, 4'd0);
        step();
        areset = 1'b1;
        #1;
        chk("s5_err_cleared", err_spurious, 1'b0);
        step();
        areset = 1'b0;
        step();

        // Asynchronous reset in the middle of a fork.
        host_ready = 1'b0;
        card_ready = 1'b0;
        issue(0, 64'h5000, 64'h6000, 28'd4, 8'h77, 4'h7, 1'b1);
        @(negedge aclk);
        chk("s6_fork_host_valid", host_valid, 1'b1);
        #2;
        areset = 1'b1;
        #1;
        chk("s6_rst_host_valid", host_valid, 1'b0);
        chk("s6_rst_card_valid", card_valid, 1'b0);
        chk("s6_rst_outstanding", outstanding, 4'd0);
        hq.delete();
        cq.delete();
        tq0.delete();
        step();
        areset = 1'b0;
        host_ready = 1'b1;
        card_ready = 1'b1;
        step();
        single_req();

        chk("end_host_queue_empty", 64'(hq.size()), 64'd0);
        chk("end_done_queue_empty", 64'(tq0.size() + tq2.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
